// File: rtl/timer_share_arbiter_if.sv
// Bundle between N requesters, the arbiter and the single shared down-count timer.
// No latency of its own; it only carries the wires.
// Requesters hold REQ until they get an ACK; the timer is paced by RESET/START/READY.
interface timer_share_arbiter_if #(
  parameter int N = 4,
  parameter int W = 8
);
  logic [N-1:0]   REQ;
  logic [N*W-1:0] DLY;
  logic [N-1:0]   GNT;
  logic [N-1:0]   ACK;
  logic           BUSY;
  logic           TMR_RESET;
  logic           TMR_START;
  logic [W-1:0]   TMR_COUNT;
  logic           TMR_READY;

  // Requester and timer side: drives requests, delays and timer expiry.
  modport master (
    output REQ, DLY, TMR_READY,
    input  GNT, ACK, BUSY, TMR_RESET, TMR_START, TMR_COUNT
  );

  // Arbiter side.
  modport slave (
    input  REQ, DLY, TMR_READY,
    output GNT, ACK, BUSY, TMR_RESET, TMR_START, TMR_COUNT
  );
endinterface

// File: rtl/timer_share_arbiter.sv
// Round-robin sharing of one down-count timer: clear, start, wait, then a one-cycle ACK to the winner.
// Latency: REQ at edge e gives TMR_START in the cycle after e. TMR_READY at edge k gives ACK in the cycle after k.
// Backpressure: a requester holds REQ until ACK. Dropping REQ while waiting aborts the grant with no ACK.
module timer_share_arbiter #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  timer_share_arbiter_if.slave  bus
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ST   = 2'd1,
    HD   = 2'd2,
    DT   = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] ptr;       // last granted requester
  logic [IW-1:0] idx;       // requester currently being served
  logic [W-1:0]  count;     // delay latched at grant
  logic [IW-1:0] win;
  logic          win_vld;
  logic [W-1:0]  win_dly;
  logic [IW-1:0] scan;
  logic [N-1:0]  sel;

  // Pick the first active request scanning upward from ptr+1, wrapping.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    scan    = '0;
    for (int k = 1; k <= N; k++) begin
      scan = IW'((int'(ptr) + k) % N);
      if (!win_vld && bus.REQ[scan]) begin
        win_vld = 1'b1;
        win     = scan;
      end
    end
  end

  assign win_dly = bus.DLY[int'(win)*W +: W];
  assign sel     = {{(N-1){1'b0}}, 1'b1} << idx;

  // Next-state: a zero delay skips the timer entirely; a withdrawn request beats expiry.
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE: begin
        if (win_vld) state_nxt = (win_dly == '0) ? DT : ST;
        else         state_nxt = IDLE;
      end
      ST:      state_nxt = HD;
      HD: begin
        if (!bus.REQ[idx])      state_nxt = IDLE;
        else if (bus.TMR_READY) state_nxt = DT;
        else                    state_nxt = HD;
      end
      DT:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore outputs decoded from the state and the latched winner. Default is the IDLE view.
  always_comb begin
    bus.GNT       = '0;
    bus.ACK       = '0;
    bus.BUSY      = 1'b0;
    bus.TMR_RESET = 1'b1;
    bus.TMR_START = 1'b0;
    case (state)
      ST: begin
        bus.GNT       = sel;
        bus.BUSY      = 1'b1;
        bus.TMR_RESET = 1'b0;
        bus.TMR_START = 1'b1;
      end
      HD: begin
        bus.GNT       = sel;
        bus.BUSY      = 1'b1;
        bus.TMR_RESET = 1'b0;
      end
      DT: begin
        bus.GNT  = sel;
        bus.ACK  = sel;
        bus.BUSY = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.TMR_COUNT = count;

  // State register. Winner, pointer and delay are captured only on a grant out of IDLE.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      ptr   <= IW'(N - 1);
      idx   <= '0;
      count <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && win_vld) begin
        ptr   <= win;
        idx   <= win;
        count <= win_dly;
      end
    end
  end

endmodule

// File: tb/tb_timer_share_arbiter.sv
// Scoreboard bench for timer_share_arbiter with a behavioural shared-timer model.
// Expected ACKs are queued when a request is driven and compared when the DUT pulses ACK.
// Every wait is bounded; the summary line is always reached.
module tb_timer_share_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;

  timer_share_arbiter_if #(.N(N), .W(W)) bus ();

  timer_share_arbiter #(.N(N), .W(W)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int ack_cyc  = 0;
  int start_cnt = 0;
  int t0;
  int s0;

  logic [N-1:0] exp_q[$];
  logic [N-1:0] mon_exp;

  // Timer model: READY rises three cycles after the START cycle for a count of 3.
  logic         m_run = 1'b0;
  logic         m_rdy = 1'b0;
  logic [W-1:0] m_cnt = '0;
  logic         force_rdy = 1'b0;

  always @(posedge CLK) begin
    if (bus.TMR_RESET) begin
      m_run <= 1'b0;
      m_rdy <= 1'b0;
      m_cnt <= '0;
    end else if (bus.TMR_START) begin
      m_run <= 1'b1;
      m_rdy <= 1'b0;
      m_cnt <= bus.TMR_COUNT - W'(1);
    end else if (m_run) begin
      if (m_cnt <= W'(1)) begin
        m_rdy <= 1'b1;
        m_run <= 1'b0;
      end else begin
        m_cnt <= m_cnt - W'(1);
      end
    end
  end

  assign bus.TMR_READY = m_rdy | force_rdy;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // Monitor: count start pulses and score every ACK against the queue.
  always @(negedge CLK) begin
    if (bus.TMR_START) start_cnt++;
    if (bus.ACK != '0) begin
      ack_cyc = cyc;
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        chk("ack", 32'(bus.ACK), 32'(mon_exp));
        chk("ack_gnt", 32'(bus.GNT), 32'(mon_exp));
      end else begin
        chk("ack_unexp", 32'(bus.ACK), 32'h0);
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_acks(input int budget);
    int i;
    i = 0;
    while (exp_q.size() > 0 && i < budget) begin
      @(negedge CLK);
      #1;
      i++;
    end
    if (exp_q.size() > 0) begin
      chk("ack_timeout", 32'(exp_q.size()), 32'h0);
      exp_q.delete();
    end
  endtask

  initial begin
    bus.REQ = '0;
    bus.DLY = '0;

    // Reset state
    step();
    step();
    @(negedge CLK);
    chk("rst_busy", 32'(bus.BUSY), 32'h0);
    chk("rst_tmr_reset", 32'(bus.TMR_RESET), 32'h1);
    chk("rst_gnt", 32'(bus.GNT), 32'h0);
    chk("rst_ack", 32'(bus.ACK), 32'h0);
    chk("rst_start", 32'(bus.TMR_START), 32'h0);
    chk("rst_count", 32'(bus.TMR_COUNT), 32'h0);
    step();
    RESET = 1'b0;

    // 1) single requester 0 with a delay of 3
    bus.DLY = {8'd5, 8'd5, 8'd5, 8'd3};
    exp_q.push_back(4'b0001);
    bus.REQ = 4'b0001;
    t0 = cyc;
    s0 = start_cnt;
    step();
    @(negedge CLK);
    chk("t1_gnt", 32'(bus.GNT), 32'h1);
    chk("t1_start", 32'(bus.TMR_START), 32'h1);
    chk("t1_tmr_reset", 32'(bus.TMR_RESET), 32'h0);
    chk("t1_count", 32'(bus.TMR_COUNT), 32'h3);
    chk("t1_busy", 32'(bus.BUSY), 32'h1);
    wait_acks(40);
    chk("t1_latency", 32'(ack_cyc - t0), 32'd5);
    step();
    bus.REQ = '0;
    chk("t1_starts", 32'(start_cnt - s0), 32'd1);

    // 2) all four requesting, round robin from requester 0 after reset
    RESET = 1'b1;
    step();
    step();
    RESET = 1'b0;
    bus.DLY = {8'd1, 8'd1, 8'd1, 8'd1};
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0001);
    bus.REQ = 4'b1111;
    wait_acks(100);
    step();
    bus.REQ = '0;
    @(negedge CLK);
    chk("t2_idle_busy", 32'(bus.BUSY), 32'h0);

    // 3) zero delay skips the timer
    bus.DLY = {8'd1, 8'd0, 8'd1, 8'd1};
    exp_q.push_back(4'b0100);
    step();
    s0 = start_cnt;
    bus.REQ = 4'b0100;
    t0 = cyc;
    wait_acks(20);
    chk("t3_latency", 32'(ack_cyc - t0), 32'd1);
    step();
    bus.REQ = '0;
    chk("t3_starts", 32'(start_cnt - s0), 32'd0);

    // 4) requester 1 withdraws while waiting; requester 2 is served next
    bus.DLY = {8'd1, 8'd2, 8'd10, 8'd1};
    bus.REQ = 4'b0010;
    step();
    step();
    @(negedge CLK);
    chk("t4_gnt", 32'(bus.GNT), 32'h2);
    chk("t4_hd_start", 32'(bus.TMR_START), 32'h0);
    step();
    exp_q.push_back(4'b0100);
    bus.REQ = 4'b0100;
    step();
    @(negedge CLK);
    chk("t4_abort_busy", 32'(bus.BUSY), 32'h0);
    chk("t4_abort_tmr_reset", 32'(bus.TMR_RESET), 32'h1);
    chk("t4_abort_gnt", 32'(bus.GNT), 32'h0);
    step();
    @(negedge CLK);
    chk("t4_next_gnt", 32'(bus.GNT), 32'h4);
    wait_acks(40);
    step();
    bus.REQ = '0;

    // 5) reset while waiting with READY high
    bus.REQ = 4'b0010;
    step();
    step();
    force_rdy = 1'b1;
    RESET = 1'b1;
    step();
    @(negedge CLK);
    chk("t5_busy", 32'(bus.BUSY), 32'h0);
    chk("t5_gnt", 32'(bus.GNT), 32'h0);
    chk("t5_ack", 32'(bus.ACK), 32'h0);
    chk("t5_tmr_reset", 32'(bus.TMR_RESET), 32'h1);
    step();
    RESET = 1'b0;
    force_rdy = 1'b0;
    bus.DLY = {8'd1, 8'd1, 8'd10, 8'd0};
    exp_q.push_back(4'b0001);
    bus.REQ = 4'b0011;
    t0 = cyc;
    wait_acks(20);
    chk("t5_latency", 32'(ack_cyc - t0), 32'd1);
    step();
    bus.REQ = '0;

    // 6) READY forced during the start cycle
    bus.DLY = {8'd1, 8'd1, 8'd10, 8'd1};
    exp_q.push_back(4'b0010);
    bus.REQ = 4'b0010;
    t0 = cyc;
    step();
    force_rdy = 1'b1;
    step();
    @(negedge CLK);
    chk("t6_hd_gnt", 32'(bus.GNT), 32'h2);
    chk("t6_hd_ack", 32'(bus.ACK), 32'h0);
    chk("t6_hd_start", 32'(bus.TMR_START), 32'h0);
    wait_acks(10);
    chk("t6_latency", 32'(ack_cyc - t0), 32'd3);
    step();
    force_rdy = 1'b0;
    bus.REQ = '0;

    // Quiet tail: any stray ACK is flagged by the monitor.
    repeat (8) step();
    @(negedge CLK);
    chk("end_busy", 32'(bus.BUSY), 32'h0);
    chk("end_queue", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
